// File: rtl/tx_sample_scheduler.sv
// Round-robin burst arbiter for two I/Q sources onto one serializer path with zero-fill.
// Optional statistics counters are built when TX_SCHED_STATS_EN is defined.
module tx_sample_scheduler #(
    parameter logic [7:0] MAX_UNDERRUN = 8'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [13:0] s0_i,
    input  logic [13:0] s0_q,
    input  logic        s0_valid,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic [13:0] s1_i,
    input  logic [13:0] s1_q,
    input  logic        s1_valid,
    input  logic        s1_last,
    output logic        s1_ready,
    output logic [13:0] out_i,
    output logic [13:0] out_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  grant,
    output logic        abort,
    output logic [15:0] underrun_cnt,
    output logic [15:0] burst_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t      state, state_next;
    logic        last_grant;
    logic [7:0]  consec;
    logic        hs;
    logic        accept;
    logic        src_valid;
    logic        src_last;
    logic [13:0] src_i;
    logic [13:0] src_q;
    logic        underrun;
    logic        at_limit;
    logic        burst_done;

    assign hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        src_valid  = 1'b0;
        src_last   = 1'b0;
        src_i      = '0;
        src_q      = '0;
        if (state == GRANT0) begin
            src_valid = s0_valid;
            src_last  = s0_last;
            src_i     = s0_i;
            src_q     = s0_q;
        end else if (state == GRANT1) begin
            src_valid = s1_valid;
            src_last  = s1_last;
            src_i     = s1_i;
            src_q     = s1_q;
        end
        accept     = (state != IDLE) && hs && en;
        underrun   = accept && !src_valid;
        at_limit   = ({1'b0, consec} + 9'd1) == {1'b0, MAX_UNDERRUN};
        burst_done = accept && src_valid && src_last;
        case (state)
            IDLE: begin
                // last_grant=1 means s1 went last, so a tie goes to s0
                if (en && s0_valid && s1_valid) state_next = last_grant ? GRANT0 : GRANT1;
                else if (en && s0_valid)        state_next = GRANT0;
                else if (en && s1_valid)        state_next = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (hs && !en)                   state_next = IDLE;
                else if (burst_done)             state_next = IDLE;
                else if (underrun && at_limit)   state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is withheld when en is low or in reset so no sample is consumed then
    always_comb begin
        s0_ready = (state == GRANT0) && hs && en && !rst;
        s1_ready = (state == GRANT1) && hs && en && !rst;
        grant    = '0;
        case (state)
            GRANT0:  grant = 2'b01;
            GRANT1:  grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_i      <= '0;
            out_q      <= '0;
            out_valid  <= 1'b0;
            abort      <= 1'b0;
            consec     <= '0;
            last_grant <= 1'b1;
        end else begin
            out_valid <= 1'b1;
            abort     <= underrun && at_limit;
            if (hs) begin
                if (accept && src_valid) begin
                    out_i <= src_i;
                    out_q <= src_q;
                end else begin
                    out_i <= '0;
                    out_q <= '0;
                end
            end
            if (state == IDLE)                    consec <= '0;
            else if (hs && !en)                   consec <= '0;
            else if (accept && src_valid)         consec <= '0;
            else if (underrun && at_limit)        consec <= '0;
            else if (underrun)                    consec <= consec + 8'd1;
            if (state == IDLE && state_next == GRANT0) last_grant <= 1'b0;
            if (state == IDLE && state_next == GRANT1) last_grant <= 1'b1;
        end
    end

`ifdef TX_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
            burst_cnt    <= '0;
        end else begin
            if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            if (burst_done)                           burst_cnt    <= burst_cnt + 16'd1;
        end
    end
`else
    assign underrun_cnt = '0;
    assign burst_cnt    = '0;
`endif

endmodule

// File: tb/tb_tx_sample_scheduler.sv
// Directed self-checking bench for tx_sample_scheduler (inputs driven and outputs sampled at negedge).
module tb_tx_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [13:0] s0_i, s0_q, s1_i, s1_q;
    logic        s0_valid, s0_last, s0_ready;
    logic        s1_valid, s1_last, s1_ready;
    logic [13:0] out_i, out_q;
    logic        out_valid, out_ready;
    logic [1:0]  grant;
    logic        abort;
    logic [15:0] underrun_cnt, burst_cnt;

    int checks = 0;
    int errors = 0;

`ifdef TX_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    always #5 clk = ~clk;

    tx_sample_scheduler #(.MAX_UNDERRUN(8'd16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s0_i(s0_i), .s0_q(s0_q), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_i(s1_i), .s1_q(s1_q), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .abort(abort), .underrun_cnt(underrun_cnt), .burst_cnt(burst_cnt)
    );

    task automatic clear_sources();
        s0_i = '0; s0_q = '0; s0_valid = 1'b0; s0_last = 1'b0;
        s1_i = '0; s1_q = '0; s1_valid = 1'b0; s1_last = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_sources();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; out_ready = 1'b1;
        clear_sources();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if ({out_i, out_q} !== 28'd0) begin errors++; $display("FAIL rst_out_data: got %h/%h exp 0/0", out_i, out_q); end
        checks++; if ({s0_ready, s1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", {s0_ready, s1_ready}); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b exp 00", grant); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL rst_abort: got %b exp 0", abort); end
        checks++; if ({underrun_cnt, burst_cnt} !== 32'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d exp 0/0", underrun_cnt, burst_cnt); end
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL idle_out_valid c%0d: got %b exp 1", c, out_valid); end
            checks++; if ({out_i, out_q} !== 28'd0) begin errors++; $display("FAIL idle_zero c%0d: got %h/%h exp 0/0", c, out_i, out_q); end
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL idle_grant c%0d: got %b exp 00", c, grant); end
        end
    endtask

    task automatic test_single_burst();
        logic [13:0] eq;
        en = 1'b1; out_ready = 1'b1;
        s0_valid = 1'b1; s0_i = 14'd1; s0_q = 14'h3FFF; s0_last = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_grant: got %b exp 01", grant); end
        for (int k = 1; k <= 4; k++) begin
            eq = 14'(-k);
            s0_i = 14'(k); s0_q = eq; s0_last = (k == 4);
            #1;
            checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL burst_ready k%0d: got %b exp 1", k, s0_ready); end
            @(negedge clk);
            checks++; if (out_i !== 14'(k) || out_q !== eq) begin errors++; $display("FAIL burst_data k%0d: got %h/%h exp %h/%h", k, out_i, out_q, 14'(k), eq); end
        end
        s0_valid = 1'b0; s0_last = 1'b0;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_idle: got %b exp 00", grant); end
        checks++; if (burst_cnt !== 16'(STATS)) begin errors++; $display("FAIL burst_cnt: got %0d exp %0d", burst_cnt, STATS); end
    endtask

    task automatic test_round_robin();
        logic [1:0] got [4];
        logic [1:0] exp_seq [4];
        logic [1:0] prev;
        int n, idx0, idx1;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1; s0_i = 14'd100; s1_i = 14'd200;
        n = 0; idx0 = 0; idx1 = 0; prev = 2'b00;
        for (int c = 0; c < 20 && n < 4; c++) begin
            s0_last = (idx0 % 2 == 1);
            s1_last = (idx1 % 2 == 1);
            #1;
            if (grant !== 2'b00 && grant !== prev) begin got[n] = grant; n++; end
            prev = grant;
            if (s0_ready) idx0++;
            if (s1_ready) idx1++;
            @(negedge clk);
        end
        clear_sources();
        checks++; if (n != 4) begin errors++; $display("FAIL rr_timeout: got %0d grants exp 4", n); end
        for (int j = 0; j < n; j++) begin
            checks++; if (got[j] !== exp_seq[j]) begin errors++; $display("FAIL rr_order %0d: got %b exp %b", j, got[j], exp_seq[j]); end
        end
    endtask

    task automatic test_underrun();
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        s1_valid = 1'b1; s1_i = 14'd7; s1_q = 14'd8; s1_last = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ur_grant: got %b exp 10", grant); end
        s1_valid = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            #1;
            checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL ur_ready n%0d: got %b exp 1", n, s1_ready); end
            @(negedge clk);
            checks++; if ({out_i, out_q} !== 28'd0) begin errors++; $display("FAIL ur_zero n%0d: got %h/%h exp 0/0", n, out_i, out_q); end
            if (n < 16) begin
                checks++; if (abort !== 1'b0) begin errors++; $display("FAIL ur_early_abort n%0d: got %b exp 0", n, abort); end
                checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ur_hold n%0d: got %b exp 10", n, grant); end
            end
        end
        checks++; if (abort !== 1'b1) begin errors++; $display("FAIL ur_abort: got %b exp 1", abort); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ur_idle: got %b exp 00", grant); end
        checks++; if (underrun_cnt !== 16'(16 * STATS)) begin errors++; $display("FAIL ur_cnt: got %0d exp %0d", underrun_cnt, 16 * STATS); end
        checks++; if (burst_cnt !== 16'd0) begin errors++; $display("FAIL ur_burst_cnt: got %0d exp 0", burst_cnt); end
        @(negedge clk);
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL ur_abort_pulse: got %b exp 0", abort); end
    endtask

    task automatic test_ready_toggle();
        int idx;
        logic [13:0] exp_i, exp_q;
        en = 1'b1; out_ready = 1'b1;
        s0_valid = 1'b1; s0_i = 14'd10; s0_q = 14'd20; s0_last = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rt_grant: got %b exp 01", grant); end
        idx = 0; exp_i = '0; exp_q = '0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            checks++; if (out_i !== exp_i || out_q !== exp_q) begin errors++; $display("FAIL rt_hold c%0d: got %h/%h exp %h/%h", c, out_i, out_q, exp_i, exp_q); end
            out_ready = (c % 2 == 0);
            s0_i = 14'(10 + idx); s0_q = 14'(20 + idx); s0_last = (idx == 3);
            #1;
            checks++; if (s0_ready !== out_ready) begin errors++; $display("FAIL rt_ready c%0d: got %b exp %b", c, s0_ready, out_ready); end
            if (s0_ready) begin exp_i = 14'(10 + idx); exp_q = 14'(20 + idx); idx++; end
            @(negedge clk);
        end
        s0_valid = 1'b0; s0_last = 1'b0; out_ready = 1'b1;
        checks++; if (idx != 4) begin errors++; $display("FAIL rt_count: got %0d exp 4", idx); end
        checks++; if (out_i !== 14'd13 || out_q !== 14'd23) begin errors++; $display("FAIL rt_final: got %h/%h exp 000d/0017", out_i, out_q); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rt_idle: got %b exp 00", grant); end
    endtask

    task automatic test_en_and_rst();
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        s0_valid = 1'b1; s0_i = 14'd55; s0_q = 14'd56; s0_last = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL en_grant: got %b exp 01", grant); end
        @(negedge clk);
        checks++; if (out_i !== 14'd55) begin errors++; $display("FAIL en_first: got %h exp 0037", out_i); end
        en = 1'b0;
        #1;
        checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL en_ready: got %b exp 0", s0_ready); end
        @(negedge clk);
        checks++; if ({out_i, out_q} !== 28'd0) begin errors++; $display("FAIL en_zero: got %h/%h exp 0/0", out_i, out_q); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL en_idle: got %b exp 00", grant); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL en_abort: got %b exp 0", abort); end
        checks++; if (burst_cnt !== 16'd0) begin errors++; $display("FAIL en_burst_cnt: got %0d exp 0", burst_cnt); end
        en = 1'b1; s0_i = 14'd66; s0_q = 14'd67;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_regrant: got %b exp 01", grant); end
        @(negedge clk);
        checks++; if (out_i !== 14'd66) begin errors++; $display("FAIL rst_first: got %h exp 0042", out_i); end
        rst = 1'b1;
        #1;
        checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b exp 0", s0_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b exp 0", out_valid); end
        checks++; if ({out_i, out_q} !== 28'd0) begin errors++; $display("FAIL rst_mid_data: got %h/%h exp 0/0", out_i, out_q); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_mid_grant: got %b exp 00", grant); end
        checks++; if ({s0_ready, s1_ready, abort} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl: got %b exp 000", {s0_ready, s1_ready, abort}); end
        checks++; if ({underrun_cnt, burst_cnt} !== 32'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d/%0d exp 0/0", underrun_cnt, burst_cnt); end
        rst = 1'b0;
        clear_sources();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_underrun();
        test_ready_toggle();
        test_en_and_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
